// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states,
// SRAM geometry constants and the byte-address to word-offset helper.
package arm_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        WAIT,
        DONE
    } mem_state_e;

    localparam int SRAM_BASE_ADDR = 1024;
    localparam int SRAM_DQ_W      = 16;

    // Word offset from the SRAM base; the shift discards byte-lane bits [1:0].
    function automatic logic [31:0] sram_word_offset(input logic [31:0] address,
                                                      input logic [31:0] base);
        return (address - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side request/response signals and external SRAM pins of the
// MEM-stage controller, bundled with master (environment) and slave (controller) views.
interface sram_mem_controller_if
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W = 18
);
    logic                 rd_en;
    logic                 wr_en;
    logic [31:0]          address;
    logic [31:0]          write_data;
    logic [31:0]          read_data;
    logic                 ready;
    logic [ADDR_W-1:0]    sram_addr;
    logic [SRAM_DQ_W-1:0] sram_dq_out;
    logic [SRAM_DQ_W-1:0] sram_dq_in;
    logic                 sram_dq_oe;
    logic                 sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller_wait_counter.sv
// Down-counter that times the post-access wait states; tc flags that the
// current cycle is the last wait cycle.
module sram_wait_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: turns a 32-bit load/store into two 16-bit SRAM
// accesses plus fixed wait states, holding ready low until the word completes.
module sram_mem_controller
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 6,
    parameter int ADDR_W      = 18,
    parameter int BASE_ADDR   = SRAM_BASE_ADDR
) (
    input logic                  clk,
    input logic                  rst,
    sram_mem_controller_if.slave bus
);
    // The two access cycles plus DONE account for three of WAIT_CYCLES.
    localparam int WAIT_LEN = WAIT_CYCLES - 3;
    localparam int CNT_W    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = (WAIT_LEN > 0) ? CNT_W'(WAIT_LEN - 1) : '0;

    mem_state_e           state;
    mem_state_e           state_nxt;
    logic [ADDR_W-2:0]    word_q;
    logic [31:0]          wdata_q;
    logic                 is_write_q;
    logic [SRAM_DQ_W-1:0] rd_lo_q;
    logic [31:0]          read_data_q;
    logic [31:0]          word_full;
    logic                 unused_word_bits;
    logic                 request;
    logic                 accept;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 cnt_clear;
    logic                 cnt_tc;

    assign request          = bus.rd_en | bus.wr_en;
    assign word_full        = sram_word_offset(bus.address, 32'(BASE_ADDR));
    assign unused_word_bits = ^word_full[31:ADDR_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_clear = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    accept    = 1'b1;
                    state_nxt = ACC_LO;
                end
            end
            ACC_LO: state_nxt = ACC_HI;
            ACC_HI: begin
                cnt_load  = 1'b1;
                state_nxt = (WAIT_LEN > 0) ? WAIT : DONE;
            end
            WAIT: begin
                if (cnt_tc) begin
                    state_nxt = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                // A request still held here belongs to the access just finished.
                cnt_clear = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    sram_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .load    (cnt_load),
        .load_val(LOAD_VAL),
        .en      (cnt_en),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            word_q     <= word_full[ADDR_W-2:0];
            wdata_q    <= bus.write_data;
            is_write_q <= bus.wr_en;
        end
        if (state == ACC_LO) begin
            rd_lo_q <= bus.sram_dq_in;
        end
    end

    // The low half is parked so read_data changes only once the whole word is in.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
        end else if ((state == ACC_HI) && !is_write_q) begin
            read_data_q <= {bus.sram_dq_in, rd_lo_q};
        end
    end

    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        case (state)
            ACC_LO: begin
                bus.sram_addr = {word_q, 1'b0};
                if (is_write_q) begin
                    bus.sram_dq_out = wdata_q[15:0];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                end
            end
            ACC_HI: begin
                bus.sram_addr = {word_q, 1'b1};
                if (is_write_q) begin
                    bus.sram_dq_out = wdata_q[31:16];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.read_data = read_data_q;
    assign bus.ready     = ((state == IDLE) && !request) || (state == DONE);
endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed vector table, back-to-back and
// reset-abort sequences, then random loads/stores against a word-level model.
module tb_sram_mem_controller;
    localparam int W    = 6;
    localparam int AW   = 18;
    localparam int BASE = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_mem_controller_if #(.ADDR_W(AW)) bus ();

    sram_mem_controller #(
        .WAIT_CYCLES(W),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // External 16-bit SRAM device model
    logic [15:0] sram [0:(1<<AW)-1];
    assign bus.sram_dq_in = sram[bus.sram_addr];
    always @(posedge clk) begin
        if (!bus.sram_we_n) sram[bus.sram_addr] <= bus.sram_dq_out;
    end

    // Word-level reference: one 32-bit entry per word index, plus last load value
    logic [31:0] ref_mem [0:255];
    logic [31:0] ref_rd;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        logic [31:0]   exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'(BASE)) >> 2;
        return int'(off & ((32'd1 << (AW - 1)) - 32'd1));
    endfunction

    // Entered 1ns after the edge that opens request cycle t; leaves at t+W+1 (+1ns)
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [AW-1:0] exp_lo,
                          input logic [AW-1:0] exp_hi, input logic [31:0] exp_rd);
        logic w;
        w = wr;
        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = a;
        bus.write_data = d;
        #3;
        check("stall_at_t", 32'(bus.ready), 32'd0);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #4;
            check("ready", 32'(bus.ready), (k == W) ? 32'd1 : 32'd0);
            if (k == 1) begin
                check("addr_lo", 32'(bus.sram_addr), 32'(exp_lo));
                check("we_n_lo", 32'(bus.sram_we_n), 32'(!w));
                check("oe_lo", 32'(bus.sram_dq_oe), 32'(w));
                check("dq_lo", 32'(bus.sram_dq_out), w ? 32'(d[15:0]) : 32'd0);
            end else if (k == 2) begin
                check("addr_hi", 32'(bus.sram_addr), 32'(exp_hi));
                check("we_n_hi", 32'(bus.sram_we_n), 32'(!w));
                check("oe_hi", 32'(bus.sram_dq_oe), 32'(w));
                check("dq_hi", 32'(bus.sram_dq_out), w ? 32'(d[31:16]) : 32'd0);
            end else begin
                check("we_n_wait", 32'(bus.sram_we_n), 32'd1);
                check("oe_wait", 32'(bus.sram_dq_oe), 32'd0);
                check("dq_wait", 32'(bus.sram_dq_out), 32'd0);
            end
            if (k == W) check("read_data", bus.read_data, exp_rd);
        end
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic model_update(input logic wr, input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx = widx(a);
        if (idx < 256) begin
            if (wr) ref_mem[idx] = d;
            else    ref_rd = ref_mem[idx];
        end
    endtask

    task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d);
        int idx;
        logic [31:0] exp_rd;
        idx = widx(a);
        exp_rd = wr ? ref_rd : ref_mem[idx];
        model_update(wr, a, d);
        access(rd, wr, a, d, AW'(2 * idx), AW'(2 * idx + 1), exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_rd = 32'h0;

        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 18'd1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 18'd1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 18'd2, 18'd3, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1030, 32'h0, 18'd2, 18'd3, 32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4, 18'd5, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'd1035, 32'h0, 18'd4, 18'd5, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 18'd1, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 1'b1, 32'd1020, 32'h0BAD0BAD, 18'h3FFFE, 18'h3FFFF, 32'hDEADBEEF};

        rst            = 1'b1;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        repeat (3) @(posedge clk);
        #4;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("rst_dq_out", 32'(bus.sram_dq_out), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_read_data", bus.read_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #4;
            check("idle_ready", 32'(bus.ready), 32'd1);
            check("idle_we_n", 32'(bus.sram_we_n), 32'd1);
            check("idle_oe", 32'(bus.sram_dq_oe), 32'd0);
        end
        @(posedge clk);
        #1;

        // Back-to-back: each request is still held in DONE, next starts at t+7
        for (int i = 0; i < 8; i++) begin
            model_update(vecs[i].wr, vecs[i].addr, vecs[i].data);
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].lo, vecs[i].hi, vecs[i].exp_rd);
        end
        #3;
        check("no_reaccept_ready", 32'(bus.ready), 32'd1);
        check("no_reaccept_we_n", 32'(bus.sram_we_n), 32'd1);
        @(posedge clk);
        #1;

        model_access(1'b0, 1'b1, 32'(BASE + 20), 32'hA5A50001);
        model_access(1'b1, 1'b0, 32'(BASE + 20), 32'h0);

        // Reset during the first half-word of a store
        bus.wr_en      = 1'b1;
        bus.address    = 32'd2000;
        bus.write_data = 32'h55AA33CC;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        #3;
        check("abort_we_n_t1", 32'(bus.sram_we_n), 32'd0);
        check("abort_addr_t1", 32'(bus.sram_addr), 32'd488);
        @(posedge clk);
        #4;
        check("abort_we_n_t2", 32'(bus.sram_we_n), 32'd1);
        check("abort_oe_t2", 32'(bus.sram_dq_oe), 32'd0);
        check("abort_read_data", bus.read_data, 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_addr_t2", 32'(bus.sram_addr), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ref_rd = 32'h0;
        @(posedge clk);
        #4;
        check("post_abort_we_n", 32'(bus.sram_we_n), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            int          op;
            int          idx;
            logic [31:0] a;
            logic [31:0] d;
            op  = int'($urandom_range(0, 3));
            idx = int'($urandom_range(0, 63));
            a   = 32'(BASE + idx * 4) + 32'($urandom_range(0, 3));
            d   = $urandom;
            model_access(op != 1, op != 0 && op != 2, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
